// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock falls and checks the device ACK.
module ps2_tx #(
  parameter int CLK_HOLD_CYC = 5000,
  parameter int RTS_CYC      = 50,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       wr_vld,
  input  logic [7:0] wr_data,
  output logic       wr_rdy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [3:0]  fall_cnt_r, fall_cnt_s;
  logic [7:0]  byte_r, byte_s;
  logic        par_r, par_s;
  logic        ack_r, ack_s;
  logic        clk_oe_r, clk_oe_s;
  logic        data_oe_r, data_oe_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        rdy_r, busy_r;
  logic        clk_meta_r, clk_sync_r, clk_prev_r;
  logic        data_meta_r, data_sync_r;
  logic        fall_s, timeout_s;

  // Pad synchronizers; idle-high reset values avoid a false fall after reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r;

  // Next-state, counter and output-value logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + 32'd1;
    fall_cnt_s = fall_cnt_r;
    byte_s     = byte_r;
    par_s      = par_r;
    ack_s      = ack_r;
    clk_oe_s   = clk_oe_r;
    data_oe_s  = data_oe_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    timeout_s  = 1'b0;

    case (state_r)
      IDLE: begin
        clk_oe_s   = 1'b0;
        data_oe_s  = 1'b0;
        cnt_s      = 32'd0;
        fall_cnt_s = 4'd0;
        if (wr_vld && rdy_r) begin
          byte_s   = wr_data;
          par_s    = odd_parity(wr_data);
          clk_oe_s = 1'b1;
          state_s  = INHIBIT;
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b0;
        if (cnt_r == 32'(CLK_HOLD_CYC - 1)) begin
          cnt_s     = 32'd0;
          data_oe_s = 1'b1;
          state_s   = RTS;
        end else begin
          state_s = INHIBIT;
        end
      end
      RTS: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b1;
        if (cnt_r == 32'(RTS_CYC - 1)) begin
          cnt_s      = 32'd0;
          fall_cnt_s = 4'd0;
          clk_oe_s   = 1'b0;
          state_s    = SEND;
        end else begin
          state_s = RTS;
        end
      end
      SEND: begin
        clk_oe_s = 1'b0;
        // The count before increment is the index of the bit this fall launches.
        if (fall_s) begin
          fall_cnt_s = fall_cnt_r + 4'd1;
          if (fall_cnt_r < 4'd8) begin
            data_oe_s = ~byte_r[fall_cnt_r[2:0]];
          end else if (fall_cnt_r == 4'd8) begin
            data_oe_s = ~par_r;
          end else begin
            data_oe_s = 1'b0;
            state_s   = ACK;
          end
        end else begin
          state_s = SEND;
        end
      end
      ACK: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        if (fall_s) begin
          fall_cnt_s = fall_cnt_r + 4'd1;
          ack_s      = data_sync_r;
          state_s    = WAIT_IDLE;
        end else begin
          state_s = ACK;
        end
      end
      WAIT_IDLE: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        if (clk_sync_r && data_sync_r) begin
          done_s  = ~ack_r;
          err_s   = ack_r;
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        state_s   = IDLE;
      end
    endcase

    // Timeout overrides any completion decided above on the same cycle.
    if ((state_r == SEND || state_r == ACK || state_r == WAIT_IDLE) &&
        (cnt_r == 32'(TIMEOUT_CYC - 1))) begin
      timeout_s = 1'b1;
      clk_oe_s  = 1'b0;
      data_oe_s = 1'b0;
      done_s    = 1'b0;
      err_s     = 1'b1;
      state_s   = IDLE;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // State, datapath and registered outputs; wr_rdy waits one cycle past a pulse.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 32'd0;
      fall_cnt_r <= 4'd0;
      byte_r     <= 8'd0;
      par_r      <= 1'b0;
      ack_r      <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdy_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      fall_cnt_r <= fall_cnt_s;
      byte_r     <= byte_s;
      par_r      <= par_s;
      ack_r      <= ack_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      done_r     <= done_s;
      err_r      <= err_s;
      rdy_r      <= (state_s == IDLE) && !done_s && !err_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign wr_rdy      = rdy_r;
  assign tx_busy     = busy_r;
  assign tx_done     = done_r;
  assign tx_err      = err_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: open-drain bus with a behavioural PS/2 device.
module tb_ps2_tx;
  localparam int HOLD = 40;
  localparam int RTSC = 8;
  localparam int TMO  = 2000;
  localparam int H    = 16;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_vld  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       wr_rdy, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, rts_cnt = 0;
  logic prev_pulse = 1'b0;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_tx #(.CLK_HOLD_CYC(HOLD), .RTS_CYC(RTSC), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((b >> i) & 8'd1) != 8'd0;
      if (f[i]) ones++;
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Pulse, bus-phase and wr_rdy-after-pulse monitor.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      if (ps2_clk_oe && ps2_data_oe) rts_cnt++;
      if (prev_pulse) chk("rdy_after_pulse", wr_rdy, 1);
      if (tx_done || tx_err) chk("pulse_exclusive_rdy_low", {tx_done & tx_err, wr_rdy}, 0);
      prev_pulse = tx_done | tx_err;
    end
  end

  task automatic start_send(input logic [7:0] b);
    int n;
    done_cnt = 0; err_cnt = 0; inh_cnt = 0; rts_cnt = 0;
    n = 0;
    while (!wr_rdy && n < 100) begin @(negedge clk_sys); n++; end
    chk("rdy_before_send", wr_rdy, 1);
    wr_data = b; wr_vld = 1'b1;
    @(negedge clk_sys);
    wr_vld = 1'b0; wr_data = 8'($urandom);
    chk("accept_busy_rdy_clkoe", {tx_busy, wr_rdy, ps2_clk_oe}, 3'b101);
    n = 0;
    while (ps2_clk_oe && n < HOLD + RTSC + 20) begin @(negedge clk_sys); n++; end
    chk("clk_released", ps2_clk_oe, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic ack, input int abort_at,
                            input logic inject);
    logic [9:0] got;
    start_send(b);
    chk("start_bit", ps2_data_in, 0);
    repeat (4) @(negedge clk_sys);
    got = 10'd0;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) begin
        repeat (4) @(negedge clk_sys);
        rst_n = 1'b0;
        @(negedge clk_sys);
        chk("abort_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, wr_rdy}, 6'b000001);
        rst_n = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("abort_no_pulse", done_cnt + err_cnt, 0);
        return;
      end
      repeat (H) @(negedge clk_sys);
      got[k-1] = ps2_data_in;
      if (inject && k == 3) begin
        wr_vld = 1'b1; wr_data = 8'h00;
        @(negedge clk_sys);
        wr_vld = 1'b0;
      end
      dev_clk = 1'b1;
      repeat (H) @(negedge clk_sys);
    end
    chk("frame_bits", got, exp_frame(b));
    chk("inhibit_len", inh_cnt, HOLD);
    chk("rts_len", rts_cnt, RTSC);
    if (ack) dev_data = 1'b0;
    repeat (H / 2) @(negedge clk_sys);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk_sys);
    dev_clk = 1'b1;
    repeat (H / 2) @(negedge clk_sys);
    dev_data = 1'b1;
    repeat (30) @(negedge clk_sys);
    chk("done_count", done_cnt, ack ? 1 : 0);
    chk("err_count", err_cnt, ack ? 0 : 1);
    chk("idle_after_frame", {ps2_clk_oe, ps2_data_oe, tx_busy, wr_rdy}, 4'b0001);
  endtask

  initial begin
    int n;
    logic [7:0] rb;
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, wr_rdy}, 6'b000001);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("idle_outputs", {ps2_clk_oe, ps2_data_oe, tx_busy, wr_rdy}, 4'b0001);

    send_frame(8'hF4, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b1, 0, 1'b0);
    send_frame(8'hF4, 1'b0, 0, 1'b0);

    // Device never clocks: timeout counted from the first SEND cycle.
    start_send(8'h3C);
    n = 0;
    while (!tx_err && n < TMO + 50) begin @(negedge clk_sys); n++; end
    chk("timeout_err", tx_err, 1);
    chk("timeout_cycles", (n == TMO) || (n == TMO + 1), 1);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk_sys);
    chk("timeout_rdy", wr_rdy, 1);
    chk("timeout_no_done", done_cnt, 0);

    send_frame(8'hA5, 1'b1, 0, 1'b1);
    inh_cnt = 0; rts_cnt = 0;
    repeat (100) @(negedge clk_sys);
    chk("no_second_frame", inh_cnt + rts_cnt, 0);

    send_frame(8'hF4, 1'b1, 5, 1'b0);
    send_frame(8'hF4, 1'b1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'($urandom_range(0, 3) != 0), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
